seven_seg_scanner: RTL
======================

# seven_seg_scanner

Multiplexed seven-segment display driver that sits directly downstream of the clock divider. It consumes the divider's slow square wave, which is generated in the `clk_in` domain, as a scan-rate reference. On every rising edge of that wave it advances to the next digit, drives that digit's active-low anode, and outputs the hex-decoded segment pattern. All logic runs on `clk_in`; the divided wave is used only as a sampled data signal, never as a clock.

## Interface
- `N_DIGITS`, default 8: number of multiplexed digits, legal range 1..8.
- `clk_in`  input  1  system clock; the only clock.
- `reset`  input  1  synchronous, active-low reset.
- `scan_clk`  input  1  divided square wave from the clock divider, synchronous to `clk_in`.
- `value`  input  4*N_DIGITS  hex nibbles; digit i = `value[4i+3:4i]`.
- `digit_en`  input  N_DIGITS  per-digit enable; 0 blanks that digit.
- `dp_in`  input  N_DIGITS  per-digit decimal point request, active-high.
- `anodes`  output  N_DIGITS  digit select, active-low, one-cold.
- `segments`  output  7  `{g,f,e,d,c,b,a}`, active-low.
- `dp`  output  1  decimal point, active-low.
- `digit_idx`  output  max(1,$clog2(N_DIGITS))  current digit index.

## Operation
- Edge detect:
  - `scan_prev` samples `scan_clk` every cycle.
  - `tick = scan_clk & ~scan_prev`, combinational.
- Index:
  - `idx_next = tick ? (idx == N_DIGITS-1 ? 0 : idx+1) : idx`.
  - `idx <= idx_next` every cycle.
  - With N_DIGITS=1, `idx` stays 0.
- Outputs are registered. Every cycle they are recomputed from `idx_next` and the current `value`, `digit_en`, and `dp_in`:
  - If `digit_en[idx_next]`=1:
    - `anodes` = all ones except bit `idx_next` = 0.
    - `segments` = decode of nibble `idx_next`.
    - `dp` = `~dp_in[idx_next]`.
  - If `digit_en[idx_next]`=0: `anodes` = all ones, `segments` = 7'h7F, `dp` = 1. The index still advances normally.
- Decode (hex, active-low `{g..a}`):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- `digit_idx` is the registered `idx`.
- Reset (`reset`=0 at a `clk_in` edge):
  - `idx`=0 and `scan_prev`=1.
  - `anodes` all ones, `segments`=7'h7F, `dp`=1, `digit_idx`=0.
  - Presetting `scan_prev`=1 means a `scan_clk` that is already high when reset releases does not produce a tick.

## Timing
- Tick latency: if `scan_clk` rises between edges k-1 and k, then at edge k `tick`=1. `anodes`, `segments`, `dp`, and `digit_idx` show the new digit after edge k.
- Data latency: a change on `value`, `digit_en`, or `dp_in` reaches the outputs after the next `clk_in` edge.
- Edge counting:
  - `scan_clk` held high produces exactly one tick.
  - `scan_clk` falling edges have no effect.
  - One digit advance per `scan_clk` period, independent of duty cycle.
- Wrap: the digit after N_DIGITS-1 is 0, in the same cycle as the tick.
- Simultaneous reset and `scan_clk` rise: reset wins. `idx`=0 and `scan_prev`=1, so no tick is taken later for that edge.
- Reset mid-scan: takes effect at the next edge regardless of `idx`. On the first edge with `reset`=1, digit 0 is displayed (no tick is possible on that edge).
- No combinational path from any input to any output.

## Test plan
- Reset and release, with N_DIGITS=8, `value`=32'h76543210, `digit_en`=8'hFF, `dp_in`=0, and `scan_clk` held at 1 throughout:
  - During reset: `anodes`=FF, `segments`=7F, `dp`=1, `digit_idx`=0.
  - One edge after release: `anodes`=FE, `segments`=40, `digit_idx`=0.
  - No advance for 20 cycles.
- Drive 9 `scan_clk` rising edges (4 cycles high, 4 cycles low):
  - `anodes` = FD, FB, F7, EF, DF, BF, 7F, FE, FD.
  - `segments` = 79, 24, 30, 19, 12, 02, 78, 40, 79.
  - Each change lands 1 cycle after the rising edge.
- Duty cycle: hold `scan_clk` high for 50 cycles, then low for 1 cycle, then high -> exactly 2 advances.
- Blanking, with `digit_enable`=8'hFB and a scan reaching idx 2:
  - At idx 2: `anodes`=FF, `segments`=7F, `dp`=1, `digit_idx`=2.
  - The next tick shows idx 3 with `anodes`=F7.
- Decimal point and data latency, with `dp_in`=8'h04 at idx 2 and `value` nibble 2 changed from 2 to E:
  - `dp`=0.
  - `segments` goes 24 -> 06 one cycle after the change.
- Reset at idx 5: pulse `reset`=0 for 1 cycle, coincident with a `scan_clk` rise:
  - Next edge: reset values.
  - On release, idx 0 is shown (`anodes`=FE) and the coincident edge is not counted.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Multiplexed seven-segment display driver. A slow square wave from the clock
// divider (generated in the clk_in domain) is sampled as data; each rising edge
// of that wave advances the scan to the next digit. For the digit being shown
// the driver pulls its anode low, drives the hex-decoded segment pattern and
// the decimal point. All outputs are registered on clk_in.
//
// Parameters
//   N_DIGITS   number of multiplexed digits, 1..8
//
// Ports
//   clk_in     in   1             system clock (the only clock)
//   reset      in   1             synchronous reset, active-low
//   scan_clk   in   1             divided scan wave, synchronous to clk_in
//   value      in   4*N_DIGITS    hex nibbles, digit i = value[4i+3:4i]
//   digit_en   in   N_DIGITS      per-digit enable, 0 blanks the digit
//   dp_in      in   N_DIGITS      per-digit decimal point request, active-high
//   anodes     out  N_DIGITS      digit select, active-low, one-cold
//   segments   out  7             {g,f,e,d,c,b,a}, active-low
//   dp         out  1             decimal point, active-low
//   digit_idx  out  IDX_W         index of the digit currently shown
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int N_DIGITS = 8,
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [N_DIGITS-1:0]     anodes,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  // Hex to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic                 scan_prev_q;
  logic                 tick_s;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic [3:0]           nibble_s;
  logic [N_DIGITS-1:0]  sel_s;
  logic [N_DIGITS-1:0]  anodes_q;
  logic [N_DIGITS-1:0]  anodes_d;
  logic [6:0]           segments_q;
  logic [6:0]           segments_d;
  logic                 dp_q;
  logic                 dp_d;

  // Rising edge of the sampled scan wave. scan_prev_q resets to 1 so a wave
  // that is already high when reset releases is not mistaken for an edge.
  always_comb begin
    tick_s = scan_clk & ~scan_prev_q;
  end

  // Next digit index: advance on a tick, wrapping after the last digit.
  // With a single digit LAST_IDX is 0, so the index never leaves 0.
  always_comb begin
    idx_d = idx_q;
    if (tick_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Output pattern for the digit about to be shown. Computing from idx_d
  // (not idx_q) makes the new digit appear on the same edge as the tick.
  always_comb begin
    nibble_s   = value[4*idx_d +: 4];
    sel_s      = '0;
    sel_s[idx_d] = 1'b1;
    anodes_d   = {N_DIGITS{1'b1}};
    segments_d = 7'h7F;
    dp_d       = 1'b1;
    if (digit_en[idx_d]) begin
      anodes_d   = ~sel_s;
      segments_d = hex_to_seg(nibble_s);
      dp_d       = ~dp_in[idx_d];
    end else begin
      anodes_d   = {N_DIGITS{1'b1}};
      segments_d = 7'h7F;
      dp_d       = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      scan_prev_q <= 1'b1;
      idx_q       <= '0;
      anodes_q    <= {N_DIGITS{1'b1}};
      segments_q  <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      scan_prev_q <= scan_clk;
      idx_q       <= idx_d;
      anodes_q    <= anodes_d;
      segments_q  <= segments_d;
      dp_q        <= dp_d;
    end
  end

  assign anodes    = anodes_q;
  assign segments  = segments_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule
